// File: rtl/inst_queue.sv
// +--------------------------------------------------------------------------+
// | inst_queue : fetch->decode instruction prefetch queue ({pc, inst})       |
// | Optional zero-latency pass-through when INST_QUEUE_BYPASS_EN is defined. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module inst_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       IF_over,
  input  logic [63:0]                IF_ID_bus,
  output logic                       IF_allow_in,
  input  logic                       ID_allow_in,
  output logic                       ID_valid,
  output logic [63:0]                ID_bus,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  logic [63:0]     r_mem [DEPTH];
  logic [c_AW-1:0] r_wp;
  logic [c_AW-1:0] r_rp;
  logic [c_CW-1:0] r_count;
  logic            r_overflow;

  logic w_full;
  logic w_empty;
  logic w_bypass;
  logic w_consumed;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);

`ifdef INST_QUEUE_BYPASS_EN
  // Empty queue with a fresh fetch: present it to decode straight away.
  assign w_bypass   = w_empty && IF_over && !flush;
  assign w_consumed = w_bypass && ID_allow_in;
  assign ID_bus     = w_empty ? IF_ID_bus : r_mem[r_rp];
`else
  assign w_bypass   = 1'b0;
  assign w_consumed = 1'b0;
  assign ID_bus     = r_mem[r_rp];
`endif

  assign ID_valid    = !w_empty || w_bypass;
  assign IF_allow_in = !w_full;
  assign count       = r_count;
  assign overflow    = r_overflow;

  // An entry taken by decode through the bypass never lands in storage.
  assign w_push = IF_over && !w_full && !flush && !w_consumed;
  assign w_pop  = ID_allow_in && !w_empty && !flush;

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wp] <= IF_ID_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (IF_over && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_queue.sv
// +--------------------------------------------------------------------------+
// | tb_inst_queue : self-checking bench for inst_queue (queue-based model)   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_inst_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        IF_over;
  logic [63:0] IF_ID_bus;
  logic        IF_allow_in;
  logic        ID_allow_in;
  logic        ID_valid;
  logic [63:0] ID_bus;
  logic        flush;
  logic [$clog2(DEPTH):0] count;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] m_q[$];
  bit          m_ovf;

  inst_queue #(.DEPTH(DEPTH)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .IF_over     (IF_over),
    .IF_ID_bus   (IF_ID_bus),
    .IF_allow_in (IF_allow_in),
    .ID_allow_in (ID_allow_in),
    .ID_valid    (ID_valid),
    .ID_bus      (ID_bus),
    .flush       (flush),
    .count       (count),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic bypass_on();
`ifdef INST_QUEUE_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Drive one cycle of inputs, compare outputs with the model, advance one edge.
  task automatic step(input logic rs, input logic ov, input logic [63:0] bus,
                      input logic alw, input logic fl);
    logic exp_valid;
    logic bp;
    int   sz;
    reset = rs; IF_over = ov; IF_ID_bus = bus; ID_allow_in = alw; flush = fl;
    #1;
    sz = m_q.size();
    bp = bypass_on() && (sz == 0) && ov && !fl;
    exp_valid = (sz != 0) || bp;
    check("count", 64'(count), 64'(sz));
    check("if_allow_in", 64'(IF_allow_in), 64'(sz != DEPTH));
    check("id_valid", 64'(ID_valid), 64'(exp_valid));
    check("overflow", 64'(overflow), 64'(m_ovf));
    if (sz != 0) check("id_bus", ID_bus, m_q[0]);
    else if (bp) check("id_bus_bypass", ID_bus, bus);
    @(posedge clk);
    #1;
    if (rs) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else if (fl) begin
      m_q.delete();
    end else begin
      if (ov && sz == DEPTH) m_ovf = 1'b1;
      if (!(bp && alw)) begin
        if (alw && sz != 0) void'(m_q.pop_front());
        if (ov && sz != DEPTH) m_q.push_back(bus);
      end
    end
  endtask

  function automatic logic [63:0] mk(input logic [31:0] pc);
    return {pc, $urandom()};
  endfunction

  task automatic drain();
    for (int k = 0; k < DEPTH + 1 && m_q.size() != 0; k++) step(0, 0, 64'd0, 1, 0);
  endtask

  initial begin
    reset = 1'b1; IF_over = 1'b0; IF_ID_bus = '0; ID_allow_in = 1'b0; flush = 1'b0;
    m_ovf = 1'b0;
    @(posedge clk);
    #1;

    // Reset held two cycles with a push request present
    step(1, 1, mk(32'h100), 0, 0);
    step(1, 1, mk(32'h104), 0, 0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(ID_valid), 64'd0);
    check("rst_allow", 64'(IF_allow_in), 64'd1);
    check("rst_ovf", 64'(overflow), 64'd0);

    // Fill then drain in order
    for (int i = 0; i < 4; i++) step(0, 1, mk(32'(i * 4)), 0, 0);
    check("fill_count", 64'(count), 64'd4);
    check("fill_allow", 64'(IF_allow_in), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", 64'(ID_bus[63:32]), 64'(i * 4));
      step(0, 0, 64'd0, 1, 0);
    end
    check("drain_empty", 64'(ID_valid), 64'd0);

    // Overflow: push while full with a pop in the same cycle
    for (int i = 0; i < 4; i++) step(0, 1, mk(32'(i * 4)), 0, 0);
    step(0, 1, mk(32'h10), 1, 0);
    check("ovf_count", 64'(count), 64'd3);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_head", 64'(ID_bus[63:32]), 64'h4);
    drain();

    // Streaming across pointer wrap
    step(0, 1, mk(32'hBFC0_0000), 0, 0);
    for (int i = 1; i <= 20; i++) begin
      check("stream_pc", 64'(ID_bus[63:32]), 64'(32'hBFC0_0000 + 32'(4 * (i - 1))));
      step(0, 1, mk(32'hBFC0_0000 + 32'(4 * i)), 1, 0);
      check("stream_count", 64'(count), 64'd1);
    end
    drain();

    // Flush with a simultaneous push
    for (int i = 0; i < 3; i++) step(0, 1, mk(32'h200 + 32'(4 * i)), 0, 0);
    check("pre_flush_count", 64'(count), 64'd3);
    step(0, 1, mk(32'h40), 0, 1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(ID_valid), 64'd0);
    step(0, 1, mk(32'h80), 0, 0);
    check("post_flush_head", 64'(ID_bus[63:32]), 64'h80);
    drain();

`ifdef INST_QUEUE_BYPASS_EN
    reset = 1'b0; IF_over = 1'b1; IF_ID_bus = mk(32'h20); ID_allow_in = 1'b1; flush = 1'b0;
    #1;
    check("bypass_valid", 64'(ID_valid), 64'd1);
    check("bypass_pc", 64'(ID_bus[63:32]), 64'h20);
    step(0, 1, IF_ID_bus, 1, 0);
    check("bypass_count", 64'(count), 64'd0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           {$urandom(), $urandom()}, ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 24) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
